// File: rtl/led_pwm_nch.sv
// N-channel LED driver: per-channel STATIC / BLINK / PWM / BREATHE with a global phase-align sync.
// led_sts is registered (1-cycle latency from inputs); led is led_sts with optional inversion.
module led_pwm_nch #(
  parameter int CH_CNT       = 3,
  parameter int CNT_W        = 32,
  parameter int DUTY_W       = 8,
  parameter int INVERSE_MODE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sync,
  input  logic [CH_CNT-1:0]        enable,
  input  logic [2*CH_CNT-1:0]      mode,
  input  logic [CH_CNT-1:0]        hold,
  input  logic [CNT_W*CH_CNT-1:0]  period,
  input  logic [DUTY_W*CH_CNT-1:0] duty,
  output logic [CH_CNT-1:0]        led_sts,
  output logic [CH_CNT-1:0]        led
);

  typedef enum logic [1:0] {
    M_STATIC  = 2'b00,
    M_BLINK   = 2'b01,
    M_PWM     = 2'b10,
    M_BREATHE = 2'b11
  } mode_e;

  localparam logic              INV    = (INVERSE_MODE != 0);
  localparam logic [DUTY_W-1:0] PH_MAX = '1;

  assign led = led_sts ^ {CH_CNT{INV}};

  for (genvar i = 0; i < CH_CNT; i++) begin : g_ch
    logic [CNT_W-1:0]  cnt, cnt_n, per;
    logic [DUTY_W-1:0] phase, phase_n, bduty, bduty_n, dty;
    logic              blink, blink_n, dir, dir_n, run, run_n, sts, sts_n;
    logic              en_q, restart;
    mode_e             md, mode_q;

    assign md  = mode_e'(mode[2*i +: 2]);
    assign per = period[CNT_W*i +: CNT_W];
    assign dty = duty[DUTY_W*i +: DUTY_W];

    // run gates mode-change restarts so nothing starts on its own after reset
    assign restart = enable[i] & (~en_q | sync | (run & (md != mode_q)));

    always_comb begin
      cnt_n   = cnt;
      blink_n = blink;
      phase_n = phase;
      bduty_n = bduty;
      dir_n   = dir;
      run_n   = run;
      sts_n   = sts;
      if (!enable[i]) begin
        cnt_n   = '0;
        blink_n = 1'b0;
        phase_n = '0;
        bduty_n = '0;
        dir_n   = 1'b0;
        run_n   = 1'b0;
        sts_n   = 1'b0;
      end else if (restart) begin
        cnt_n   = '0;
        blink_n = 1'b1;
        phase_n = '0;
        bduty_n = '0;
        dir_n   = 1'b0;
        run_n   = 1'b1;
        case (md)
          M_STATIC: sts_n = hold[i];
          M_BLINK:  sts_n = 1'b1;
          M_PWM:    sts_n = (dty != '0);
          default:  sts_n = 1'b0;
        endcase
      end else if (!run) begin
        sts_n = 1'b0;
      end else if (md == M_STATIC) begin
        sts_n = hold[i];
      end else begin
        if (cnt == per) begin
          cnt_n   = '0;
          blink_n = ~blink;
          phase_n = phase + 1'b1;
          // frame end: endpoints hold one extra frame while dir flips
          if (md == M_BREATHE && phase == PH_MAX) begin
            if (!dir) begin
              if (bduty >= dty) dir_n = 1'b1;
              else              bduty_n = bduty + 1'b1;
            end else begin
              if (bduty == '0)  dir_n = 1'b0;
              else              bduty_n = bduty - 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
        case (md)
          M_BLINK: sts_n = blink_n;
          M_PWM:   sts_n = (phase_n < dty);
          default: sts_n = (phase_n < bduty_n);
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        blink  <= 1'b0;
        phase  <= '0;
        bduty  <= '0;
        dir    <= 1'b0;
        run    <= 1'b0;
        sts    <= 1'b0;
        // a held-high enable must not look like a rising edge after reset
        en_q   <= 1'b1;
        mode_q <= M_STATIC;
      end else begin
        cnt    <= cnt_n;
        blink  <= blink_n;
        phase  <= phase_n;
        bduty  <= bduty_n;
        dir    <= dir_n;
        run    <= run_n;
        sts    <= sts_n;
        en_q   <= enable[i];
        mode_q <= md;
      end
    end

    assign led_sts[i] = sts;
  end

endmodule

// File: tb/tb_led_pwm_nch.sv
// Bench for led_pwm_nch: two instances (DUTY_W=4 inverted, DUTY_W=8 non-inverted) against a
// closed-form per-channel waveform model feeding a scoreboard queue.
module tb_led_pwm_nch;

  localparam int CH = 3;
  localparam int CW = 16;

  logic          clk, reset, sync;
  logic [CH-1:0] enable, hold;
  logic [2*CH-1:0]  mode;
  logic [CW*CH-1:0] period;
  logic [4*CH-1:0]  duty4;
  logic [8*CH-1:0]  duty8;
  logic [CH-1:0] sts4, led4, sts8, led8;

  led_pwm_nch #(.CH_CNT(CH), .CNT_W(CW), .DUTY_W(4), .INVERSE_MODE(1)) dut_a (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .mode(mode), .hold(hold),
    .period(period), .duty(duty4), .led_sts(sts4), .led(led4));

  led_pwm_nch #(.CH_CNT(CH), .CNT_W(CW), .DUTY_W(8), .INVERSE_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .mode(mode), .hold(hold),
    .period(period), .duty(duty8), .led_sts(sts8), .led(led8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [CH-1:0] s4;
    logic [CH-1:0] s8;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // model state: channel running since a restart, cycles elapsed since that restart
  bit       en_prev  [CH];
  bit [1:0] mode_prev[CH];
  bit       run      [CH];
  longint   t        [CH];

  // expected level t cycles after a restart, from the mode's waveform definition
  function automatic bit exp_led(bit [1:0] md, bit hv, longint tt, longint p, longint d, int dw);
    longint st, ph, fr, f, k, bd;
    fr = longint'(1) << dw;
    st = tt / (p + 1);
    ph = st % fr;
    case (md)
      2'b00:   return hv;
      2'b01:   return (st % 2) == 0;
      2'b10:   return ph < d;
      default: begin
        f  = st / fr;
        k  = f % (2 * (d + 1));
        bd = (k <= d) ? k : (2 * d + 1 - k);
        return ph < bd;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      en_prev[c] = 1'b1;
      run[c]     = 1'b0;
      t[c]       = 0;
    end
  endtask

  // one clock: predict the post-edge outputs from the inputs now applied, then advance
  task automatic tick();
    exp_t     e;
    bit       en, rs;
    bit [1:0] md;
    for (int c = 0; c < CH; c++) begin
      en = enable[c];
      md = mode[2*c +: 2];
      if (!en) begin
        run[c] = 1'b0;
      end else begin
        rs = !en_prev[c] || sync || (run[c] && md != mode_prev[c]);
        if (rs) begin
          run[c] = 1'b1;
          t[c]   = 0;
        end else if (run[c]) begin
          t[c]++;
        end
      end
      e.s4[c] = (en && run[c]) ? exp_led(md, hold[c], t[c], longint'(period[CW*c +: CW]),
                                         longint'(duty4[4*c +: 4]), 4) : 1'b0;
      e.s8[c] = (en && run[c]) ? exp_led(md, hold[c], t[c], longint'(period[CW*c +: CW]),
                                         longint'(duty8[8*c +: 8]), 8) : 1'b0;
      en_prev[c]   = en;
      mode_prev[c] = md;
    end
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cycles(int n);
    for (int k = 0; k < n; k++) begin
      sync = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 49) == 0) hold = hold ^ CH'(1 << $urandom_range(0, CH - 1));
      tick();
      sync = 1'b0;
    end
  endtask

  task automatic restart_all(bit use_sync);
    logic [CH-1:0] saved;
    if (use_sync) begin
      sync = 1'b1;
      tick();
      sync = 1'b0;
    end else begin
      saved  = enable;
      enable = '0;
      tick();
      enable = saved;
      tick();
    end
  endtask

  task automatic check(string name, logic [CH-1:0] act, logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // monitor: outputs are valid every cycle, one scoreboard entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sts_a", sts4, e.s4);
        check("led_a", led4, ~e.s4);
        check("sts_b", sts8, e.s8);
        check("led_b", led8, e.s8);
      end
    end
  end

  task automatic set_ch(int c, bit [1:0] md, int p, int d4, int d8, bit hv);
    mode[2*c +: 2]   = md;
    period[CW*c +: CW] = CW'(p);
    duty4[4*c +: 4]  = 4'(d4);
    duty8[8*c +: 8]  = 8'(d8);
    hold[c]          = hv;
  endtask

  initial begin
    reset  = 1'b1;
    sync   = 1'b0;
    enable = '0;
    mode   = '0;
    hold   = '0;
    period = '0;
    duty4  = '0;
    duty8  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sts_a", sts4, 3'b000);
    check("reset_led_a", led4, 3'b111);
    check("reset_sts_b", sts8, 3'b000);
    check("reset_led_b", led8, 3'b000);
    reset = 1'b0;
    tick();

    // blink period 4 and period 0, static channel
    set_ch(0, 2'b01, 4, 0, 0, 1'b0);
    set_ch(1, 2'b01, 0, 0, 0, 1'b0);
    set_ch(2, 2'b00, 0, 0, 0, 1'b1);
    enable = 3'b111;
    restart_all(1'b0);
    for (int k = 0; k < 40; k++) tick();

    // pwm: quarter duty, zero duty, full-scale duty
    set_ch(0, 2'b10, 0, 4, 64, 1'b0);
    set_ch(1, 2'b10, 0, 0, 0, 1'b0);
    set_ch(2, 2'b10, 0, 15, 255, 1'b0);
    restart_all(1'b0);
    for (int k = 0; k < 600; k++) tick();

    // breathe with endpoint holds; duty 0 stays dark
    set_ch(0, 2'b11, 0, 3, 2, 1'b0);
    set_ch(1, 2'b11, 0, 0, 0, 1'b0);
    set_ch(2, 2'b11, 1, 2, 1, 1'b0);
    restart_all(1'b1);
    for (int k = 0; k < 1400; k++) tick();

    // sync alignment of skewed blinkers, ch2 disabled
    enable = '0;
    tick();
    set_ch(0, 2'b01, 9, 0, 0, 1'b0);
    set_ch(1, 2'b01, 9, 0, 0, 1'b0);
    enable = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    enable = 3'b011;
    for (int k = 0; k < 4; k++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    check("sync_aligned", {2'b00, sts4[1]}, {2'b00, sts4[0]});

    // async reset during a pwm high phase
    set_ch(0, 2'b10, 0, 8, 100, 1'b0);
    enable = 3'b001;
    restart_all(1'b0);
    for (int k = 0; k < 3; k++) tick();
    #1;
    check("pre_reset_high", {sts8[0], sts4[0]}, 2'b11);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_sts_a", sts4, 3'b000);
    check("midrst_led_a", led4, 3'b111);
    check("midrst_sts_b", sts8, 3'b000);
    check("midrst_led_b", led8, 3'b000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    mode[1:0] = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 0; k < 30; k++) tick();

    // randomized episodes: full reconfig with sync or enable restart, or mode-only change
    for (int ep = 0; ep < 20; ep++) begin
      int kind;
      kind = $urandom_range(0, 2);
      for (int c = 0; c < CH; c++) begin
        bit [1:0] md;
        md = 2'($urandom_range(0, 3));
        if (kind == 2) mode[2*c +: 2] = md;
        else set_ch(c, md, $urandom_range(0, 4), $urandom_range(0, 15),
                    (md == 2'b11) ? $urandom_range(0, 6) : $urandom_range(0, 255),
                    1'($urandom_range(0, 1)));
      end
      if (kind != 2) enable = CH'($urandom_range(1, 7));
      if (kind == 0) restart_all(1'b1);
      if (kind == 1) restart_all(1'b0);
      run_cycles($urandom_range(200, 700));
    end

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pwm_nch.md
Name: led_pwm_nch

Overview:
Parametrised N-channel LED driver core, successor to the fixed 3-channel RGB LED core. Each channel independently runs in one of four modes: STATIC, BLINK, PWM or BREATHE. The block sits behind an AXI-lite register wrapper, with configuration driven as flat per-channel buses, and drives board LED pins. It also provides a global sync pulse that phase-aligns all channels.

Parameters:
CH_CNT, 3, number of LED channels (1..16)
CNT_W, 32, width of per-channel period/prescaler counter
DUTY_W, 8, PWM resolution; a frame is 2^DUTY_W ticks
INVERSE_MODE, 1, 1 = LED pins active-low (pin = ~led_sts), 0 = active-high

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
sync  in  1  single-cycle pulse; restarts all enabled channels
enable  in  CH_CNT  per-channel enable
mode  in  2*CH_CNT  per-channel mode, ch i at [2i+1:2i]: 00 STATIC, 01 BLINK, 10 PWM, 11 BREATHE
hold  in  CH_CNT  STATIC-mode level per channel
period  in  CNT_W*CH_CNT  per-channel period; ch i at [CNT_W*i +: CNT_W]
duty  in  DUTY_W*CH_CNT  PWM duty, or BREATHE ceiling; ch i at [DUTY_W*i +: DUTY_W]
led_sts  out  CH_CNT  logical LED state before inversion (readback)
led  out  CH_CNT  board pins

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous, active-high.
- Reset values:
  - led_sts = 0.
  - led = {CH_CNT{INVERSE_MODE[0]}}.
  - All counters, phases, breathe duty and direction = 0; blink state = 0.
- Outputs:
  - led_sts is registered.
  - led = led_sts XOR INVERSE_MODE; led is combinational from the register, so there is no extra latency.
- Per-channel state: prescaler cnt (CNT_W), blink bit, phase (DUTY_W), bduty (DUTY_W), dir bit, registered copies of enable and mode.
- Restart condition: any of the following, evaluated per channel:
  - enable rises (0 -> 1).
  - mode changes while enable = 1.
  - sync = 1 while enable = 1.
- On restart (at that clock edge):
  - cnt = 0, phase = 0, bduty = 0, dir = up.
  - blink = 1.
  - led_sts is loaded with the first-cycle value of the mode.
- enable = 0: all channel state held at reset values; led_sts = 0 one cycle after enable is sampled low.
- STATIC: led_sts <= hold[i] each cycle (1-cycle latency); counters are idle.
- BLINK:
  - Tick when cnt == period; cnt then wraps to 0, otherwise cnt increments.
  - blink toggles on each tick; led_sts = blink.
  - Resulting waveform: led_sts is 1 for period+1 cycles, then 0 for period+1 cycles, starting the cycle after the restart edge.
  - period = 0 gives a toggle every cycle.
- PWM:
  - Same tick as BLINK; phase increments on each tick and wraps at 2^DUTY_W-1 -> 0.
  - led_sts = (phase < duty).
  - duty = 0 is always off; duty = 2^DUTY_W-1 is off for exactly one tick per frame.
- BREATHE:
  - Same as PWM, but the compare value is bduty instead of duty.
  - At each frame end (tick with phase == max), bduty steps by 1 in direction dir.
  - dir reverses when bduty reaches duty[i] (top) or 0 (bottom). The endpoint value is held for one frame before the reversal takes effect.
  - duty[i] = 0 keeps led_sts = 0.
- Live config updates:
  - period, duty and hold changes take effect without restart.
  - If period is lowered below the current cnt, cnt continues counting to 2^CNT_W-1 and wraps to 0. This is accepted; software must restart (toggle enable or pulse sync) for a clean change.
- Simultaneous events:
  - Restart has priority over tick.
  - sync and a mode change in the same cycle cause a single restart.
  - sync has no effect on disabled channels.
- Reset mid-operation: immediate async clear of all outputs and state. After reset release, nothing runs until a restart condition occurs.

Test Plan:
- Reset and inversion: reset=1 with INVERSE_MODE=1, CH_CNT=3 -> led=3'b111, led_sts=0. With INVERSE_MODE=0 -> led=3'b000.
- BLINK: ch0 mode=01, period=4, enable 0->1 -> led_sts[0] is 1 for 5 cycles, 0 for 5, repeating. period=0 -> alternates every cycle.
- PWM:
  - DUTY_W=8, period=0, duty=64 -> led_sts high 64 of every 256 cycles, starting at phase 0.
  - duty=0 -> never high.
  - duty=255 -> low exactly 1 cycle per 256.
- BREATHE: DUTY_W=4, period=0, duty=3 -> per 16-cycle frame, high counts are 0,1,2,3,3,2,1,0,0,1,... Verifies the endpoint hold and direction reversal.
- Sync alignment: ch0 and ch1 in BLINK with period=9 and skewed enables; pulse sync -> both channels' led_sts identical thereafter. Disabled ch2 stays 0.
- Reset mid-run: assert reset asynchronously during PWM high phase -> led_sts=0 and led=INVERSE_MODE before the next clk edge. After release with enable held at 1 -> output stays 0 until enable toggles or sync pulses.
